// File: rtl/comb_sched_pkg.sv
// Shared definitions for the two-requester datapath scheduler.
package comb_sched_pkg;
  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/comb_logic_sched_rr_arb2.sv
// Two-way round-robin grant; prio names the requester that wins a tie.
module rr_arb2
  import comb_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  logic               prio,
  output logic [NUM_REQ-1:0] grant
);
  always_comb begin
    grant = valid;
    if (&valid) begin
      grant       = '0;
      grant[prio] = 1'b1;
    end
  end
endmodule

// File: rtl/comb_logic_sched.sv
// Shares one combinational datapath between two requesters: arbitrate, register, evaluate, respond.
// Optional grant counters are enabled by defining COMB_SCHED_STATS_EN.
module comb_logic_sched
  import comb_sched_pkg::*;
#(
  parameter int DWIDTH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req_valid,
  output logic [NUM_REQ-1:0]  req_ready,
  input  logic [2*DWIDTH-1:0] req_x,
  input  logic [2*DWIDTH-1:0] req_y,
  input  logic [3:0]          req_inst,
  input  logic [1:0]          req_sel,
  output logic [DWIDTH-1:0]   dp_x,
  output logic [DWIDTH-1:0]   dp_y,
  output logic [1:0]          dp_inst,
  output logic                dp_sel,
  input  logic [DWIDTH-1:0]   dp_sum,
  input  logic                dp_cout,
  input  logic                dp_xegy,
  input  logic                dp_sel_out,
  input  logic [2*DWIDTH-1:0] dp_prod,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output logic [DWIDTH-1:0]   rsp_sum,
  output logic                rsp_cout,
  output logic                rsp_xegy,
  output logic                rsp_sel_out,
  output logic [2*DWIDTH-1:0] rsp_prod,
  output logic                busy
`ifdef COMB_SCHED_STATS_EN
  ,
  output logic [CNT_W-1:0]    gnt_cnt0,
  output logic [CNT_W-1:0]    gnt_cnt1
`endif
);
  state_t             state, state_nxt;
  logic               prio;
  logic [NUM_REQ-1:0] grant;
  logic               accept;
  logic [ID_W-1:0]    gid;

  rr_arb2 u_arb (
    .valid (req_valid),
    .prio  (prio),
    .grant (grant)
  );

  assign gid       = grant[1];
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = grant;
        accept    = |grant;
        if (accept) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // prio holds the requester favoured on a tie: the one not granted last.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      prio        <= 1'b0;
      dp_x        <= '0;
      dp_y        <= '0;
      dp_inst     <= '0;
      dp_sel      <= 1'b0;
      rsp_id      <= '0;
      rsp_sum     <= '0;
      rsp_cout    <= 1'b0;
      rsp_xegy    <= 1'b0;
      rsp_sel_out <= 1'b0;
      rsp_prod    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        dp_x    <= gid ? req_x[2*DWIDTH-1:DWIDTH] : req_x[DWIDTH-1:0];
        dp_y    <= gid ? req_y[2*DWIDTH-1:DWIDTH] : req_y[DWIDTH-1:0];
        dp_inst <= gid ? req_inst[3:2] : req_inst[1:0];
        dp_sel  <= req_sel[gid];
        rsp_id  <= gid;
        prio    <= ~gid;
      end
      if (state == EXEC) begin
        rsp_sum     <= dp_sum;
        rsp_cout    <= dp_cout;
        rsp_xegy    <= dp_xegy;
        rsp_sel_out <= dp_sel_out;
        rsp_prod    <= dp_prod;
      end
    end
  end

`ifdef COMB_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (accept) begin
      if (!gid && !(&gnt_cnt0)) gnt_cnt0 <= gnt_cnt0 + 1'b1;
      if (gid && !(&gnt_cnt1))  gnt_cnt1 <= gnt_cnt1 + 1'b1;
    end
  end
`endif
endmodule
